// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus, ID read ports and the debug tap, all bundled for wb_regfile.
// The master side (pipeline/bench) drives indices and data. The slave side (register file) returns operands and status.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write_in;
  logic                  mem_to_reg_in;
  logic [DATA_WIDTH-1:0] read_data_in;
  logic [DATA_WIDTH-1:0] ALU_result_in;
  logic [ADDR_WIDTH-1:0] mux_reg_dst_out_in;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_commit;
  logic [31:0]           retire_count;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output reg_write_in, mem_to_reg_in, read_data_in, ALU_result_in,
           mux_reg_dst_out_in, read_reg1, read_reg2, dbg_addr,
    input  read_data1, read_data2, wb_data, wb_commit, retire_count, dbg_data
  );

  modport slave (
    input  reg_write_in, mem_to_reg_in, read_data_in, ALU_result_in,
           mux_reg_dst_out_in, read_reg1, read_reg2, dbg_addr,
    output read_data1, read_data2, wb_data, wb_commit, retire_count, dbg_data
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and general-purpose register file.
// Register 0 is hardwired to zero. Both ID read ports are write-first bypassed. The debug tap returns the raw array contents.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [31:0]           retire_q;
  logic [DATA_WIDTH-1:0] wb_value;
  logic                  commit;

  assign wb_value = bus.mem_to_reg_in ? bus.read_data_in : bus.ALU_result_in;
  assign commit   = bus.reg_write_in & ~rst & (bus.mux_reg_dst_out_in != '0);

  // NOTE: the array is built from flops, not a RAM macro, so a full reset is
  // cheap enough. It also guarantees that no X escapes after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      retire_q <= '0;
    end else if (commit) begin
      regs[bus.mux_reg_dst_out_in] <= wb_value;
      retire_q                     <= retire_q + 32'd1;
    end
  end

  // A write that commits on the coming edge takes priority over the stored value.
  // This lets an instruction in ID see the value that is being written back in this cycle.
  always_comb begin
    bus.read_data1 = regs[bus.read_reg1];
    bus.read_data2 = regs[bus.read_reg2];
    if (commit && bus.mux_reg_dst_out_in == bus.read_reg1) bus.read_data1 = wb_value;
    if (commit && bus.mux_reg_dst_out_in == bus.read_reg2) bus.read_data2 = wb_value;
    if (bus.read_reg1 == '0) bus.read_data1 = '0;
    if (bus.read_reg2 == '0) bus.read_data2 = '0;
  end

  assign bus.wb_data      = wb_value;
  assign bus.wb_commit    = commit;
  assign bus.retire_count = retire_q;
  assign bus.dbg_data     = regs[bus.dbg_addr];

endmodule
